// File: rtl/trapezoid_feeder.sv
// trapezoid_feeder: queues trapezoid commands (four x/y vertex byte pairs each)
// and streams them to a renderer one vertex per cycle, waiting for the
// renderer's busy handshake between commands.
module trapezoid_feeder #(
    parameter int DEPTH   = 4,   // queued commands, power of two (>= 2)
    parameter int TIMEOUT = 16   // cycles the renderer has to raise busy
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [31:0]              wr_x,
    input  logic [31:0]              wr_y,
    input  logic                     busy,
    output logic                     nt,
    output logic [7:0]               xi,
    output logic [7:0]               yi,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} state_t;

    state_t          state;
    logic [63:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [63:0]     head;
    logic [63:0]     send_reg;
    logic [1:0]      idx;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;

    // Vertex byte i of a 32-bit word, byte 0 being the most significant.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);
    // A push into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign push  = wr_en && !full;
    assign pop   = (state == IDLE) && !empty && !busy;
    assign head  = mem[rd_ptr];

    // Command storage; contents are don't-care while the FIFO is empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_x, wr_y};
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    // Snapshot of the command being streamed, captured as it leaves the FIFO.
    always_ff @(posedge clk) begin
        if (pop) begin
            send_reg <= head;
        end
    end

    // Renderer handshake FSM with registered strobe and vertex outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            nt    <= 1'b0;
            xi    <= '0;
            yi    <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    nt <= 1'b0;
                    if (pop) begin
                        // First vertex comes straight from the FIFO head so it
                        // appears in the first SEND cycle together with nt.
                        state <= SEND;
                        idx   <= '0;
                        nt    <= 1'b1;
                        xi    <= head[63:56];
                        yi    <= head[31:24];
                    end
                end
                SEND: begin
                    nt <= 1'b0;
                    if (idx == 2'd3) begin
                        state <= ACK;
                        cnt   <= '0;
                    end else begin
                        idx <= idx + 2'd1;
                        xi  <= byte_of(send_reg[63:32], idx + 2'd1);
                        yi  <= byte_of(send_reg[31:0], idx + 2'd1);
                    end
                end
                ACK: begin
                    if (busy) begin
                        state <= DRAIN;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (!busy) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trapezoid_feeder.sv
// Scoreboard bench for trapezoid_feeder: a queue-based renderer-protocol model
// predicts accepted commands, the monitor checks every vertex burst against it.
module tb_trapezoid_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_x = '0;
    logic [31:0] wr_y = '0;
    logic        busy = 1'b0;
    logic        nt;
    logic [7:0]  xi;
    logic [7:0]  yi;
    logic        full;
    logic        empty;
    logic [$clog2(DEPTH):0] level;
    logic        ovf;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] m_q[$];      // commands waiting in the feeder
    logic [63:0] exp_q[$];    // commands expected on the renderer port, in order
    int          m_phase = 0; // 0 waiting, 1 streaming, 2 awaiting busy, 3 renderer working
    int          m_t = 0;
    bit          m_ovf = 0;
    bit          m_err = 0;

    // Monitor state
    int          b_left = 0;
    logic [63:0] b_cmd = '0;

    trapezoid_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
        .busy(busy), .nt(nt), .xi(xi), .yi(yi), .full(full), .empty(empty),
        .level(level), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] vbyte(input logic [31:0] w, input int k);
        return w[31-8*k -: 8];
    endfunction

    // Behavioural model of the feeder as seen from the outside.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_phase = 0;
            m_t = 0;
            m_ovf = 0;
            m_err = 0;
        end else begin
            int  pre;
            bit  accept;
            pre = m_q.size();
            accept = wr_en && (pre < DEPTH);
            if (wr_en && !accept) m_ovf = 1;
            if (m_phase == 0) begin
                if (pre > 0 && !busy) begin
                    exp_q.push_back(m_q.pop_front());
                    m_phase = 1;
                    m_t = 0;
                end
            end else if (m_phase == 1) begin
                // four vertex cycles, then wait for the renderer
                m_t++;
                if (m_t == 4) begin
                    m_phase = 2;
                    m_t = 0;
                end
            end else if (m_phase == 2) begin
                if (busy) m_phase = 3;
                else if (m_t == TIMEOUT - 1) begin
                    m_phase = 0;
                    m_err = 1;
                end else m_t++;
            end else begin
                if (!busy) m_phase = 0;
            end
            if (accept) m_q.push_back({wr_x, wr_y});
        end
    end

    // Monitor: every nt opens a four-vertex burst matched against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            b_left = 0;
        end else if (b_left > 0) begin
            int k;
            k = 4 - b_left;
            check("burst_nt_low", nt, 1'b0);
            check("burst_xi", xi, vbyte(b_cmd[63:32], k));
            check("burst_yi", yi, vbyte(b_cmd[31:0], k));
            b_left--;
        end else if (nt === 1'b1) begin
            check("nt_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                b_cmd = exp_q.pop_front();
                check("burst_xi", xi, vbyte(b_cmd[63:32], 0));
                check("burst_yi", yi, vbyte(b_cmd[31:0], 0));
                b_left = 3;
            end
        end
    end

    // Status flags compared against the model every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check("level", level, m_q.size());
            check("full", full, m_q.size() == DEPTH);
            check("empty", empty, m_q.size() == 0);
            check("ovf", ovf, m_ovf);
            check("err", err, m_err);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_nt(input int max_cycles, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < max_cycles; i++) begin
            if (nt === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check(name, found, 1'b1);
    endtask

    task automatic wait_drained(input int max_cycles, input string name);
        bit done;
        done = 0;
        wr_en = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && m_q.size() == 0 && m_phase == 0 && b_left == 0) begin
                done = 1;
                break;
            end
        end
        check(name, done, 1'b1);
    endtask

    task automatic push_rand();
        wr_en = 1'b1;
        wr_x = $urandom;
        wr_y = $urandom;
    endtask

    initial begin
        // Asynchronous reset values
        #1 reset = 1'b1;
        #1;
        check("rst_nt", nt, 1'b0);
        check("rst_xi", xi, 8'h00);
        check("rst_yi", yi, 8'h00);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;

        // Single command: latency and vertex order
        @(negedge clk);
        busy = 1'b0;
        wr_en = 1'b1;
        wr_x = 32'h0A141E28;
        wr_y = 32'h05050F0F;
        @(negedge clk);
        wr_en = 1'b0;
        check("lat_nt_early", nt, 1'b0);
        @(negedge clk);
        check("v0_nt", nt, 1'b1);
        check("v0_xi", xi, 8'h0A);
        check("v0_yi", yi, 8'h05);
        @(negedge clk);
        check("v1_nt", nt, 1'b0);
        check("v1_xi", xi, 8'h14);
        check("v1_yi", yi, 8'h05);
        @(negedge clk);
        check("v2_xi", xi, 8'h1E);
        check("v2_yi", yi, 8'h0F);
        @(negedge clk);
        check("v3_nt", nt, 1'b0);
        check("v3_xi", xi, 8'h28);
        check("v3_yi", yi, 8'h0F);
        @(negedge clk);
        check("hold_xi", xi, 8'h28);
        do_reset();

        // Renderer timeout, then the next queued command goes out
        @(negedge clk);
        busy = 1'b0;
        push_rand();
        @(negedge clk);
        push_rand();
        @(negedge clk);
        wr_en = 1'b0;
        wait_nt(4, "to_first_nt");
        repeat (19) @(negedge clk);
        check("to_err_before", err, 1'b0);
        @(negedge clk);
        check("to_err_set", err, 1'b1);
        @(negedge clk);
        check("to_next_nt", nt, 1'b1);
        do_reset();

        // Renderer busy handshake delays the second command
        @(negedge clk);
        busy = 1'b1;
        push_rand();
        @(negedge clk);
        push_rand();
        @(negedge clk);
        wr_en = 1'b0;
        busy = 1'b0;
        wait_nt(4, "hs_first_nt");
        repeat (6) @(negedge clk);
        busy = 1'b1;
        repeat (20) @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        check("hs_nt_early", nt, 1'b0);
        @(negedge clk);
        check("hs_second_nt", nt, 1'b1);
        wait_drained(100, "hs_drained");
        do_reset();

        // Fill to full with busy held, then overflow
        @(negedge clk);
        busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_rand();
            @(negedge clk);
            if (i == 3) begin
                check("fill_full", full, 1'b1);
                check("fill_ovf_clear", ovf, 1'b0);
            end
        end
        wr_en = 1'b0;
        check("fill_ovf_set", ovf, 1'b1);
        check("fill_level", level, 4);
        do_reset();

        // Push into a full FIFO on the same edge as a pop
        @(negedge clk);
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_rand();
            @(negedge clk);
        end
        check("pp_ovf_before", ovf, 1'b0);
        push_rand();
        busy = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        check("pp_level", level, 3);
        check("pp_ovf", ovf, 1'b1);
        wait_drained(200, "pp_drained");
        do_reset();

        // Reset in the middle of a burst
        @(negedge clk);
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_rand();
            @(negedge clk);
        end
        wr_en = 1'b0;
        busy = 1'b0;
        wait_nt(4, "mr_nt");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mr_nt_low", nt, 1'b0);
        check("mr_empty", empty, 1'b1);
        check("mr_level", level, 0);
        check("mr_xi", xi, 8'h00);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mr_no_nt", nt, 1'b0);
        end

        // Randomised traffic with a random renderer
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            wr_en = ($urandom_range(0, 2) == 0);
            wr_x = $urandom;
            wr_y = $urandom;
            if ($urandom_range(0, 5) == 0) busy = ~busy;
        end
        wait_drained(400, "rand_drained");
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
